// File: rtl/wb_commit_stage_if.sv
// MEM -> WB instruction bus with valid/allow handshake.
// MEM drives the instruction fields; WB answers with in_allow.
interface wb_commit_stage_if #(
  parameter int DATA_W  = 32,
  parameter int RF_AW   = 5,
  parameter int NUM_EXC = 16
);
  logic               in_valid;
  logic               in_allow;
  logic [DATA_W-1:0]  in_pc;
  logic               in_gr_we;
  logic [RF_AW-1:0]   in_dest;
  logic [DATA_W-1:0]  in_result;
  logic               in_csr_re;
  logic               in_csr_we;
  logic [13:0]        in_csr_num;
  logic [DATA_W-1:0]  in_csr_wmask;
  logic [DATA_W-1:0]  in_csr_wvalue;
  logic [NUM_EXC-1:0] in_exc_vec;
  logic [DATA_W-1:0]  in_vaddr;
  logic               in_ertn;
  logic               in_refetch;

  modport master (
    output in_valid, in_pc, in_gr_we, in_dest,
    output in_result, in_csr_re, in_csr_we,
    output in_csr_num, in_csr_wmask, in_csr_wvalue,
    output in_exc_vec, in_vaddr, in_ertn, in_refetch,
    input  in_allow
  );

  modport slave (
    input  in_valid, in_pc, in_gr_we, in_dest,
    input  in_result, in_csr_re, in_csr_we,
    input  in_csr_num, in_csr_wmask, in_csr_wvalue,
    input  in_exc_vec, in_vaddr, in_ertn, in_refetch,
    output in_allow
  );
endinterface

// File: rtl/wb_commit_stage.sv
// Write-back / commit stage: CSR handshake, exception select,
// flush pulses with bubble, regfile write, forwarding, trace.
module wb_commit_stage #(
  parameter int DATA_W  = 32,
  parameter int RF_AW   = 5,
  parameter int NUM_EXC = 16,
  parameter logic [NUM_EXC*6-1:0] ECODE_TABLE = '0,
  parameter logic [NUM_EXC-1:0] TLBR_MASK     = '0,
  parameter logic [NUM_EXC-1:0] PC_VADDR_MASK = '0,
  parameter int FLUSH_BUBBLE = 1,
  parameter int CNT_W        = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  wb_commit_stage_if.slave           mem,
  input  logic                       csr_ready,
  input  logic [DATA_W-1:0]          csr_rvalue,
  output logic                       csr_re,
  output logic                       csr_we,
  output logic [13:0]                csr_num,
  output logic [DATA_W-1:0]          csr_wmask,
  output logic [DATA_W-1:0]          csr_wvalue,
  output logic                       rf_we,
  output logic [RF_AW-1:0]           rf_waddr,
  output logic [DATA_W-1:0]          rf_wdata,
  output logic [RF_AW-1:0]           fwd_dest,
  output logic [DATA_W-1:0]          fwd_data,
  output logic                       fwd_data_ok,
  output logic                       flush,
  output logic [1:0]                 flush_kind,
  output logic [5:0]                 ex_ecode,
  output logic [$clog2(NUM_EXC)-1:0] ex_index,
  output logic                       ex_tlbr,
  output logic [DATA_W-1:0]          ex_pc,
  output logic [DATA_W-1:0]          ex_vaddr,
  output logic [CNT_W-1:0]           retired_cnt,
  output logic [DATA_W-1:0]          debug_wb_pc,
  output logic [3:0]                 debug_wb_rf_we,
  output logic [RF_AW-1:0]           debug_wb_rf_wnum,
  output logic [DATA_W-1:0]          debug_wb_rf_wdata
);

  localparam int IDX_W = $clog2(NUM_EXC);
  localparam logic [3:0] BUB = 4'(FLUSH_BUBBLE);

  typedef struct packed {
    logic [DATA_W-1:0]  pc;
    logic               gr_we;
    logic [RF_AW-1:0]   dest;
    logic [DATA_W-1:0]  result;
    logic               csr_re;
    logic               csr_we;
    logic [13:0]        csr_num;
    logic [DATA_W-1:0]  csr_wmask;
    logic [DATA_W-1:0]  csr_wvalue;
    logic [NUM_EXC-1:0] exc_vec;
    logic [DATA_W-1:0]  vaddr;
    logic               ertn;
    logic               refetch;
  } wb_bus_t;

  wb_bus_t    r;
  wb_bus_t    nxt;
  logic       valid;
  logic [3:0] bub_cnt;

  logic exc;
  logic need_csr;
  logic go;
  logic commit;
  logic in_allow;
  logic accept;
  logic [IDX_W-1:0] sel;

  assign nxt = '{
    pc:         mem.in_pc,
    gr_we:      mem.in_gr_we,
    dest:       mem.in_dest,
    result:     mem.in_result,
    csr_re:     mem.in_csr_re,
    csr_we:     mem.in_csr_we,
    csr_num:    mem.in_csr_num,
    csr_wmask:  mem.in_csr_wmask,
    csr_wvalue: mem.in_csr_wvalue,
    exc_vec:    mem.in_exc_vec,
    vaddr:      mem.in_vaddr,
    ertn:       mem.in_ertn,
    refetch:    mem.in_refetch
  };

  // An excepting instruction never waits on the CSR file.
  assign exc      = valid & (|r.exc_vec);
  assign need_csr = valid & (r.csr_re | r.csr_we) & ~exc;
  assign go       = ~need_csr | csr_ready;
  assign commit   = valid & go;
  assign flush    = commit & (exc | r.ertn | r.refetch);

  assign in_allow = (~valid | go) & (bub_cnt == 4'd0) & ~flush;
  assign accept   = mem.in_valid & in_allow;
  assign mem.in_allow = in_allow;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      r     <= '0;
    end else if (accept) begin
      valid <= 1'b1;
      r     <= nxt;
    end else if (commit) begin
      valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bub_cnt <= 4'd0;
    end else if (flush) begin
      bub_cnt <= BUB;
    end else if (bub_cnt != 4'd0) begin
      bub_cnt <= bub_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_cnt <= '0;
    end else if (commit & ~exc) begin
      retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

  // Descending scan so the lowest set cause wins.
  always_comb begin
    sel = '0;
    for (int i = NUM_EXC - 1; i >= 0; i--) begin
      if (r.exc_vec[i]) sel = IDX_W'(i);
    end
  end

  always_comb begin
    ex_index = '0;
    ex_ecode = 6'd0;
    ex_tlbr  = 1'b0;
    ex_pc    = '0;
    ex_vaddr = '0;
    if (exc) begin
      ex_index = sel;
      ex_ecode = ECODE_TABLE[6*sel +: 6];
      ex_tlbr  = TLBR_MASK[sel];
      ex_pc    = r.pc;
      ex_vaddr = PC_VADDR_MASK[sel] ? r.pc : r.vaddr;
    end
  end

  always_comb begin
    flush_kind = 2'd0;
    if (flush) begin
      if (exc)            flush_kind = 2'd0;
      else if (r.ertn)    flush_kind = 2'd1;
      else if (r.refetch) flush_kind = 2'd2;
    end
  end

  assign csr_re     = valid & r.csr_re & ~exc;
  assign csr_we     = valid & r.csr_we & ~exc;
  assign csr_num    = valid ? r.csr_num    : '0;
  assign csr_wmask  = valid ? r.csr_wmask  : '0;
  assign csr_wvalue = valid ? r.csr_wvalue : '0;

  assign rf_we    = commit & r.gr_we & ~exc & (r.dest != '0);
  assign rf_waddr = r.dest;
  assign rf_wdata = r.csr_re ? csr_rvalue : r.result;

  assign fwd_dest    = (valid & r.gr_we) ? r.dest : '0;
  assign fwd_data    = rf_wdata;
  assign fwd_data_ok = valid & (~r.csr_re | csr_ready);

  assign debug_wb_pc       = r.pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

  a_flush_blocks_input: assert property (
    @(posedge clk) disable iff (reset) flush |-> !in_allow);
  a_write_needs_commit: assert property (
    @(posedge clk) disable iff (reset) rf_we |-> commit);

endmodule

// File: tb/tb_wb_commit_stage.sv
// Directed bench for wb_commit_stage: one task per scenario.
// Inputs change on negedge, outputs sampled 1ns later.
module tb_wb_commit_stage;

  localparam logic [95:0] TBL =
    (96'h09 << 12) | (96'h08 << 24) | (96'h3F << 30);

  logic        clk;
  logic        reset;
  logic        csr_ready;
  logic [31:0] csr_rvalue;
  logic        csr_re, csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask, csr_wvalue;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  fwd_dest;
  logic [31:0] fwd_data;
  logic        fwd_data_ok;
  logic        flush;
  logic [1:0]  flush_kind;
  logic [5:0]  ex_ecode;
  logic [3:0]  ex_index;
  logic        ex_tlbr;
  logic [31:0] ex_pc, ex_vaddr;
  logic [63:0] retired_cnt;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int checks = 0;
  int errors = 0;

  wb_commit_stage_if #(.DATA_W(32), .RF_AW(5), .NUM_EXC(16)) bus ();

  wb_commit_stage #(
    .DATA_W(32), .RF_AW(5), .NUM_EXC(16),
    .ECODE_TABLE(TBL),
    .TLBR_MASK(16'h0020),
    .PC_VADDR_MASK(16'h0020),
    .FLUSH_BUBBLE(2),
    .CNT_W(64)
  ) dut (
    .clk(clk), .reset(reset), .mem(bus.slave),
    .csr_ready(csr_ready), .csr_rvalue(csr_rvalue),
    .csr_re(csr_re), .csr_we(csr_we), .csr_num(csr_num),
    .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_dest(fwd_dest), .fwd_data(fwd_data),
    .fwd_data_ok(fwd_data_ok),
    .flush(flush), .flush_kind(flush_kind),
    .ex_ecode(ex_ecode), .ex_index(ex_index), .ex_tlbr(ex_tlbr),
    .ex_pc(ex_pc), .ex_vaddr(ex_vaddr),
    .retired_cnt(retired_cnt),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.in_valid      = 1'b0;
    bus.in_pc         = '0;
    bus.in_gr_we      = 1'b0;
    bus.in_dest       = '0;
    bus.in_result     = '0;
    bus.in_csr_re     = 1'b0;
    bus.in_csr_we     = 1'b0;
    bus.in_csr_num    = '0;
    bus.in_csr_wmask  = '0;
    bus.in_csr_wvalue = '0;
    bus.in_exc_vec    = '0;
    bus.in_vaddr      = '0;
    bus.in_ertn       = 1'b0;
    bus.in_refetch    = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    csr_ready = 1'b0;
    csr_rvalue = '0;
    reset = 1'b1;
    step(); step();
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.in_allow !== 1'b1) begin
      errors++;
      $display("FAIL reset_allow got %b want 1", bus.in_allow);
    end
    checks++;
    if ({rf_we, flush, csr_re, csr_we, fwd_data_ok} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes got %b want 0",
               {rf_we, flush, csr_re, csr_we, fwd_data_ok});
    end
    checks++;
    if (retired_cnt !== 64'd0 || debug_wb_pc !== 32'd0) begin
      errors++;
      $display("FAIL reset_regs cnt %0d pc %h want 0 0",
               retired_cnt, debug_wb_pc);
    end
  endtask

  task automatic test_back_to_back();
    csr_ready = 1'b0;
    @(negedge clk);
    idle();
    bus.in_valid = 1'b1; bus.in_pc = 32'h1C000000;
    bus.in_gr_we = 1'b1; bus.in_dest = 5'd3; bus.in_result = 32'h11;
    #1;
    checks++;
    if (bus.in_allow !== 1'b1) begin
      errors++;
      $display("FAIL b2b_allow0 got %b want 1", bus.in_allow);
    end
    @(negedge clk);
    bus.in_pc = 32'h1C000004; bus.in_dest = 5'd5; bus.in_result = 32'h22;
    #1;
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h11
        || bus.in_allow !== 1'b1) begin
      errors++;
      $display("FAIL b2b_op1 we %b addr %0d data %h allow %b want 1 3 11 1",
               rf_we, rf_waddr, rf_wdata, bus.in_allow);
    end
    checks++;
    if (debug_wb_rf_we !== 4'hF || debug_wb_pc !== 32'h1C000000) begin
      errors++;
      $display("FAIL b2b_trace we %h pc %h want f 1c000000",
               debug_wb_rf_we, debug_wb_pc);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h22
        || retired_cnt !== 64'd1) begin
      errors++;
      $display("FAIL b2b_op2 we %b addr %0d data %h cnt %0d want 1 5 22 1",
               rf_we, rf_waddr, rf_wdata, retired_cnt);
    end
    step();
    checks++;
    if (rf_we !== 1'b0 || retired_cnt !== 64'd2) begin
      errors++;
      $display("FAIL b2b_done we %b cnt %0d want 0 2", rf_we, retired_cnt);
    end
  endtask

  task automatic test_csr_read();
    @(negedge clk);
    idle();
    bus.in_valid = 1'b1; bus.in_pc = 32'h1C000010;
    bus.in_gr_we = 1'b1; bus.in_dest = 5'd4;
    bus.in_csr_re = 1'b1; bus.in_csr_num = 14'h005;
    csr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle();
      #1;
      checks++;
      if (bus.in_allow !== 1'b0 || rf_we !== 1'b0 || fwd_data_ok !== 1'b0
          || csr_re !== 1'b1 || fwd_dest !== 5'd4 || csr_num !== 14'h005) begin
        errors++;
        $display("FAIL csr_wait%0d allow %b we %b ok %b re %b dest %0d num %h",
                 i, bus.in_allow, rf_we, fwd_data_ok, csr_re, fwd_dest, csr_num);
      end
    end
    @(negedge clk);
    csr_ready = 1'b1; csr_rvalue = 32'hABCD;
    #1;
    checks++;
    if (rf_we !== 1'b1 || rf_wdata !== 32'hABCD || fwd_data_ok !== 1'b1
        || bus.in_allow !== 1'b1 || fwd_data !== 32'hABCD) begin
      errors++;
      $display("FAIL csr_done we %b data %h ok %b allow %b want 1 abcd 1 1",
               rf_we, rf_wdata, fwd_data_ok, bus.in_allow);
    end
    @(negedge clk);
    csr_ready = 1'b0; csr_rvalue = '0;
    #1;
    checks++;
    if (rf_we !== 1'b0 || retired_cnt !== 64'd3 || fwd_dest !== 5'd0) begin
      errors++;
      $display("FAIL csr_after we %b cnt %0d fwd %0d want 0 3 0",
               rf_we, retired_cnt, fwd_dest);
    end
  endtask

  task automatic test_exception();
    @(negedge clk);
    idle();
    bus.in_valid = 1'b1; bus.in_pc = 32'h1C000040;
    bus.in_gr_we = 1'b1; bus.in_dest = 5'd7;
    bus.in_csr_we = 1'b1; bus.in_exc_vec = 16'h0014;
    bus.in_vaddr = 32'h00001234;
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (flush !== 1'b1 || flush_kind !== 2'd0 || ex_index !== 4'd2
        || ex_ecode !== 6'h09) begin
      errors++;
      $display("FAIL exc_sel flush %b kind %0d idx %0d ecode %h want 1 0 2 09",
               flush, flush_kind, ex_index, ex_ecode);
    end
    checks++;
    if (rf_we !== 1'b0 || csr_we !== 1'b0 || bus.in_allow !== 1'b0) begin
      errors++;
      $display("FAIL exc_gate we %b csr_we %b allow %b want 0 0 0",
               rf_we, csr_we, bus.in_allow);
    end
    checks++;
    if (ex_pc !== 32'h1C000040 || ex_vaddr !== 32'h00001234
        || ex_tlbr !== 1'b0) begin
      errors++;
      $display("FAIL exc_info pc %h vaddr %h tlbr %b want 1c000040 1234 0",
               ex_pc, ex_vaddr, ex_tlbr);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (flush !== 1'b0 || bus.in_allow !== 1'b0) begin
        errors++;
        $display("FAIL exc_bubble%0d flush %b allow %b want 0 0",
                 i, flush, bus.in_allow);
      end
    end
    step();
    checks++;
    if (bus.in_allow !== 1'b1 || retired_cnt !== 64'd3 || ex_ecode !== 6'd0) begin
      errors++;
      $display("FAIL exc_end allow %b cnt %0d ecode %h want 1 3 0",
               bus.in_allow, retired_cnt, ex_ecode);
    end
  endtask

  task automatic test_tlbr();
    @(negedge clk);
    idle();
    bus.in_valid = 1'b1; bus.in_pc = 32'h1C000100;
    bus.in_exc_vec = 16'h0020; bus.in_vaddr = 32'hDEAD0000;
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (flush !== 1'b1 || ex_index !== 4'd5 || ex_ecode !== 6'h3F
        || ex_tlbr !== 1'b1 || ex_vaddr !== 32'h1C000100) begin
      errors++;
      $display("FAIL tlbr flush %b idx %0d ecode %h tlbr %b vaddr %h",
               flush, ex_index, ex_ecode, ex_tlbr, ex_vaddr);
    end
    step(); step(); step();
  endtask

  task automatic test_ertn_refetch();
    @(negedge clk);
    idle();
    bus.in_valid = 1'b1; bus.in_pc = 32'h1C000200; bus.in_ertn = 1'b1;
    @(negedge clk);
    idle();
    bus.in_valid = 1'b1; bus.in_pc = 32'h1C000204; bus.in_refetch = 1'b1;
    #1;
    checks++;
    if (flush !== 1'b1 || flush_kind !== 2'd1 || bus.in_allow !== 1'b0) begin
      errors++;
      $display("FAIL ertn flush %b kind %0d allow %b want 1 1 0",
               flush, flush_kind, bus.in_allow);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (flush !== 1'b0 || bus.in_allow !== 1'b0) begin
        errors++;
        $display("FAIL ertn_bubble%0d flush %b allow %b want 0 0",
                 i, flush, bus.in_allow);
      end
    end
    step();
    checks++;
    if (bus.in_allow !== 1'b1 || retired_cnt !== 64'd4) begin
      errors++;
      $display("FAIL ertn_end allow %b cnt %0d want 1 4",
               bus.in_allow, retired_cnt);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (flush !== 1'b1 || flush_kind !== 2'd2
        || debug_wb_pc !== 32'h1C000204) begin
      errors++;
      $display("FAIL refetch flush %b kind %0d pc %h want 1 2 1c000204",
               flush, flush_kind, debug_wb_pc);
    end
    step(); step();
    checks++;
    if (bus.in_allow !== 1'b0) begin
      errors++;
      $display("FAIL refetch_bubble allow %b want 0", bus.in_allow);
    end
    step();
    checks++;
    if (bus.in_allow !== 1'b1 || retired_cnt !== 64'd5) begin
      errors++;
      $display("FAIL refetch_end allow %b cnt %0d want 1 5",
               bus.in_allow, retired_cnt);
    end
  endtask

  task automatic test_reset_mid_stall();
    csr_ready = 1'b0;
    @(negedge clk);
    idle();
    bus.in_valid = 1'b1; bus.in_pc = 32'h1C000300;
    bus.in_gr_we = 1'b1; bus.in_dest = 5'd6;
    bus.in_csr_we = 1'b1; bus.in_csr_wvalue = 32'h5A5A;
    bus.in_csr_wmask = 32'hFFFF;
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (csr_we !== 1'b1 || csr_wvalue !== 32'h5A5A || bus.in_allow !== 1'b0) begin
      errors++;
      $display("FAIL stall_pre csr_we %b wv %h allow %b want 1 5a5a 0",
               csr_we, csr_wvalue, bus.in_allow);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (csr_we !== 1'b0 || rf_we !== 1'b0 || flush !== 1'b0
        || fwd_dest !== 5'd0 || retired_cnt !== 64'd0
        || bus.in_allow !== 1'b1) begin
      errors++;
      $display("FAIL stall_reset csr_we %b we %b flush %b fwd %0d cnt %0d allow %b",
               csr_we, rf_we, flush, fwd_dest, retired_cnt, bus.in_allow);
    end
  endtask

  task automatic test_dest_zero();
    @(negedge clk);
    idle();
    bus.in_valid = 1'b1; bus.in_pc = 32'h1C000400;
    bus.in_gr_we = 1'b1; bus.in_dest = 5'd0; bus.in_result = 32'h55;
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (rf_we !== 1'b0 || debug_wb_rf_we !== 4'h0) begin
      errors++;
      $display("FAIL dest0_we we %b trace %h want 0 0", rf_we, debug_wb_rf_we);
    end
    step();
    checks++;
    if (retired_cnt !== 64'd1) begin
      errors++;
      $display("FAIL dest0_cnt cnt %0d want 1", retired_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_csr_read();
    test_exception();
    test_tlbr();
    test_ertn_refetch();
    test_reset_mid_stall();
    test_dest_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
